// File: rtl/fp8_pkg.sv
// Shared constants and types for the FP16 -> FP8 E4M3 converter stage.
package fp8_pkg;

    localparam int FP16_W     = 16;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP8_W      = 8;
    localparam int FP8_EXP_W  = 4;
    localparam int FP8_MAN_W  = 3;

    localparam int FP16_BIAS = 15;
    localparam int FP8_BIAS  = 7;

    // Magnitude encodings (sign excluded): largest finite value and NaN
    localparam logic [6:0] FP8_MAXMAG = 7'h7E;
    localparam logic [6:0] FP8_NAN    = 7'h7F;

    typedef enum logic {
        PH_LOW,
        PH_HIGH
    } phase_e;

endpackage

// File: rtl/fp8_sync_fifo.sv
// Synchronous FIFO with registered head outputs (out_valid/out_data) and occupancy level.
module fp8_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             rd_fire;

    assign rd_fire   = rd_en && valid_q;
    assign full      = (level_q == LW'(DEPTH));
    assign out_valid = valid_q;
    assign out_data  = head_q;
    assign level     = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !rd_fire) begin
            level_d = level_q + LW'(1);
        end else if (!wr_en && rd_fire) begin
            level_d = level_q - LW'(1);
        end
        valid_d = (level_d != '0);
        // Next head sees this cycle's write when it lands exactly at the new read pointer
        if (level_d == '0) begin
            head_d = '0;
        end else if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
            head_d = wr_data;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/fp16_to_fp8_converter.sv
// Reassembles byte-serial FP16 words, converts to FP8 E4M3 (RNE, saturating) and buffers them.
// Optional saturation/NaN counters are built when FP8CONV_STATS_EN is defined.
module fp16_to_fp8_converter
    import fp8_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [7:0]                    in_byte,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FP8CONV_STATS_EN
    ,
    input  logic                          stats_clr,
    output logic [7:0]                    sat_cnt,
    output logic [7:0]                    nan_cnt
`endif
);

    function automatic logic [FP8_W-1:0] fp16_to_fp8(input logic [FP16_W-1:0] w);
        logic                  s;
        logic [FP16_EXP_W-1:0] e16;
        logic [FP16_MAN_W-1:0] m;
        logic signed [5:0]     exp_u;
        logic signed [5:0]     e8;
        logic [2:0]            sa;
        logic [14:0]           sh;
        logic [2:0]            m3;
        logic                  g;
        logic                  st;
        logic                  rup;
        logic [3:0]            sum;
        logic [FP8_W-1:0]      res;
        s     = w[15];
        e16   = w[14:10];
        m     = w[9:0];
        exp_u = $signed({1'b0, e16}) - 6'sd15;
        e8    = exp_u + 6'sd7;
        sa    = '0;
        sh    = '0;
        m3    = '0;
        g     = 1'b0;
        st    = 1'b0;
        rup   = 1'b0;
        sum   = '0;
        res   = {s, 7'h00};
        if (e16 == 5'h1F) begin
            res = (m != '0) ? {s, FP8_NAN} : {s, FP8_MAXMAG};
        end else if (e16 == '0) begin
            res = {s, 7'h00};
        end else if (exp_u >= -6'sd6) begin
            m3  = m[9:7];
            g   = m[6];
            st  = |m[5:0];
            rup = g && (st || m3[0]);
            sum = {1'b0, m3} + {3'b000, rup};
            if (sum[3]) begin
                e8 = e8 + 6'sd1;
                m3 = 3'd0;
            end else begin
                m3 = sum[2:0];
            end
            if ((e8 > 6'sd15) || ((e8 == 6'sd15) && (m3 == 3'd7))) begin
                res = {s, FP8_MAXMAG};
            end else begin
                res = {s, e8[3:0], m3};
            end
        end else if (exp_u >= -6'sd10) begin
            // Subnormal: align {1,m} to the 2^-6 scale; 4 spare LSBs keep every shifted-out bit for sticky
            sa  = 3'(-6'sd6 - exp_u);
            sh  = {1'b1, m, 4'b0000} >> sa;
            g   = sh[10];
            st  = |sh[9:0];
            rup = g && (st || sh[11]);
            sum = sh[14:11] + {3'b000, rup};
            // A carry into sum[3] lands exactly on the min-normal encoding (e8=1, m8=0)
            res = {s, 3'b000, sum};
        end
        return res;
    endfunction

    phase_e      phase_q, phase_d;
    logic [7:0]  low_q, low_d;
    logic        conv_full_q, conv_full_d;
    logic [7:0]  conv_data_q, conv_data_d;
    logic        fifo_full;
    logic        fifo_wr;
    logic        accept;
    logic        load;

    assign in_ready = !(conv_full_q && fifo_full);
    assign accept   = in_valid && in_ready;
    // A same-cycle read frees a slot in a full FIFO, so the write can proceed
    assign fifo_wr  = conv_full_q && (!fifo_full || (out_valid && out_ready));

    always_comb begin
        phase_d     = phase_q;
        low_d       = low_q;
        load        = 1'b0;
        conv_full_d = conv_full_q;
        conv_data_d = conv_data_q;
        case (phase_q)
            PH_LOW: begin
                if (accept) begin
                    low_d   = in_byte;
                    phase_d = PH_HIGH;
                end
            end
            PH_HIGH: begin
                if (accept) begin
                    if (in_sof) begin
                        low_d = in_byte;
                    end else begin
                        load    = 1'b1;
                        phase_d = PH_LOW;
                    end
                end
            end
            default: phase_d = PH_LOW;
        endcase
        if (fifo_wr) begin
            conv_full_d = 1'b0;
        end
        if (load) begin
            conv_full_d = 1'b1;
            conv_data_d = fp16_to_fp8({in_byte, low_q});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= PH_LOW;
            low_q       <= '0;
            conv_full_q <= 1'b0;
            conv_data_q <= '0;
        end else begin
            phase_q     <= phase_d;
            low_q       <= low_d;
            conv_full_q <= conv_full_d;
            conv_data_q <= conv_data_d;
        end
    end

    fp8_sync_fifo #(
        .WIDTH (FP8_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (fifo_wr),
        .wr_data   (conv_data_q),
        .rd_en     (out_ready),
        .full      (fifo_full),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (fifo_level)
    );

`ifdef FP8CONV_STATS_EN
    logic [7:0] sat_cnt_q, sat_cnt_d;
    logic [7:0] nan_cnt_q, nan_cnt_d;
    logic       sat_hit;
    logic       nan_hit;

    assign sat_hit = fifo_wr && (conv_data_q[6:0] == FP8_MAXMAG);
    assign nan_hit = fifo_wr && (conv_data_q[6:0] == FP8_NAN);

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        nan_cnt_d = nan_cnt_q;
        if (stats_clr) begin
            sat_cnt_d = '0;
            nan_cnt_d = '0;
        end else begin
            if (sat_hit && (sat_cnt_q != 8'hFF)) begin
                sat_cnt_d = sat_cnt_q + 8'd1;
            end
            if (nan_hit && (nan_cnt_q != 8'hFF)) begin
                nan_cnt_d = nan_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
            nan_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
            nan_cnt_q <= nan_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
    assign nan_cnt = nan_cnt_q;
`endif

endmodule

// File: tb/tb_fp16_to_fp8_converter.sv
// Directed self-checking bench for fp16_to_fp8_converter (default FIFO_DEPTH=4).
module tb_fp16_to_fp8_converter;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [$clog2(DEPTH):0] fifo_level;
`ifdef FP8CONV_STATS_EN
    logic       stats_clr;
    logic [7:0] sat_cnt;
    logic [7:0] nan_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    fp16_to_fp8_converter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_level (fifo_level)
`ifdef FP8CONV_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .sat_cnt    (sat_cnt),
        .nan_cnt    (nan_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output handshakes are captured mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back(out_data);
            $display("tb: out byte 0x%02h (level %0d)", out_data, fifo_level);
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic sof);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_sof   = sof;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("send_in_ready", {15'd0, in_ready}, 16'd1);
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input logic [7:0] fp8);
        $display("tb: in word 0x%04h expect 0x%02h", w, fp8);
        send(w[7:0], 1'b0);
        send(w[15:8], 1'b0);
        exp_q.push_back(fp8);
    endtask

    task automatic drain_and_compare(input string tag);
        int k = 0;
        while (got_q.size() < exp_q.size() && k < 200) begin
            tick();
            k++;
        end
        check({tag, "_count"}, 16'(got_q.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s[%0d]", tag, i), {8'd0, got_q[i]}, {8'd0, exp_q[i]});
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b1;
`ifdef FP8CONV_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_data", {8'd0, out_data}, 16'h00);
        check("rst_fifo_level", 16'(fifo_level), 16'd0);

        // Latency: high byte accepted at N, out_valid at N+2
        send(8'h00, 1'b0);
        send(8'h3C, 1'b0);
        exp_q.push_back(8'h38);
        check("lat_n1_valid", {15'd0, out_valid}, 16'd0);
        tick();
        check("lat_n2_valid", {15'd0, out_valid}, 16'd1);
        check("lat_n2_data", {8'd0, out_data}, 16'h38);
        send_word(16'hC000, 8'hC0);
        drain_and_compare("basic");

        // Round to nearest even
        send_word(16'h3C40, 8'h38);
        send_word(16'h3CC0, 8'h3A);
        send_word(16'h3C41, 8'h39);
        drain_and_compare("rne");

        // Saturation and NaN
        send_word(16'h5F00, 8'h7E);
        send_word(16'h5FC0, 8'h7E);
        send_word(16'h7C00, 8'h7E);
        send_word(16'hFE00, 8'hFF);
        drain_and_compare("sat");
`ifdef FP8CONV_STATS_EN
        check("stats_sat", {8'd0, sat_cnt}, 16'd3);
        check("stats_nan", {8'd0, nan_cnt}, 16'd1);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("stats_sat_clr", {8'd0, sat_cnt}, 16'd0);
        check("stats_nan_clr", {8'd0, nan_cnt}, 16'd0);
`endif

        // Subnormals, underflow and the subnormal-to-normal rounding boundary
        send_word(16'h1C00, 8'h02);
        send_word(16'h1400, 8'h00);
        send_word(16'h1401, 8'h01);
        send_word(16'h0001, 8'h00);
        send_word(16'h8000, 8'h80);
        send_word(16'h2000, 8'h04);
        send_word(16'h23FF, 8'h08);
        send_word(16'h2400, 8'h08);
        drain_and_compare("subn");

        // Backpressure: FIFO_DEPTH words fill the FIFO, one more fills the conversion register
        out_ready = 1'b0;
        send_word(16'h3C00, 8'h38);
        send_word(16'h4000, 8'h40);
        send_word(16'h4200, 8'h44);
        send_word(16'hBC00, 8'hB8);
        check("bp_ready_after4", {15'd0, in_ready}, 16'd1);
        check("bp_level_after4", 16'(fifo_level), 16'd3);
        send_word(16'h3800, 8'h30);
        check("bp_ready_after5", {15'd0, in_ready}, 16'd0);
        check("bp_level_after5", 16'(fifo_level), 16'd4);
        in_valid = 1'b1;
        in_byte  = 8'h00;
        repeat (3) tick();
        check("bp_ready_hold", {15'd0, in_ready}, 16'd0);
        check("bp_head_valid", {15'd0, out_valid}, 16'd1);
        check("bp_head_data", {8'd0, out_data}, 16'h38);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send_word(16'h4400, 8'h48);
        drain_and_compare("bp");
        repeat (2) tick();
        check("bp_level_empty", 16'(fifo_level), 16'd0);
        check("bp_valid_empty", {15'd0, out_valid}, 16'd0);

        // Resync: in_sof in HIGH replaces the low byte; in LOW it is harmless
        send(8'hAA, 1'b0);
        send(8'h00, 1'b1);
        send(8'h3C, 1'b0);
        exp_q.push_back(8'h38);
        send(8'h00, 1'b1);
        send(8'h40, 1'b0);
        exp_q.push_back(8'hC0 ^ 8'h80);
        drain_and_compare("resync");
        repeat (5) tick();
        check("resync_no_extra", 16'(got_q.size()), 16'd0);

        // Asynchronous reset with a buffered word and a partial word pending
        out_ready = 1'b0;
        send_word(16'h3C00, 8'h38);
        send(8'h55, 1'b0);
        repeat (3) tick();
        check("rstmid_pre_valid", {15'd0, out_valid}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", {15'd0, out_valid}, 16'd0);
        check("rstmid_level", 16'(fifo_level), 16'd0);
        check("rstmid_in_ready", {15'd0, in_ready}, 16'd1);
        exp_q.delete();
        repeat (2) tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();
        check("rstmid_no_stale", 16'(got_q.size()), 16'd0);
        check("rstmid_valid_after", {15'd0, out_valid}, 16'd0);
        send_word(16'hC000, 8'hC0);
        drain_and_compare("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
